gpo_blink: RTL and testbench
============================

Name: gpo_blink

Overview:
Parametrised memory-mapped general-purpose output peripheral on the CPU data bus, driving LEDs and other static outputs. It generalises the single 8-bit output register in three ways:
- configurable output width;
- atomic write-1-to-set / clear / toggle registers;
- per-bit hardware blink mode timed by a programmable prescaler.
Software can therefore blink LEDs without polling.

Parameters:
GPO_W, 8, number of output bits (1..32)
CNT_W, 24, width of blink prescaler counter and BLINK_DIV register
ACTIVE_LOW, 0, 1 = invert every gpo bit at the pin (register values unaffected)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cs  input  1  chip select from address decoder
wr  input  1  write strobe; register write occurs when cs & wr at posedge clk
addr  input  3  word index of register
wdata  input  32  write data
rdata  output  32  read data, combinational from addr
gpo  output  GPO_W  output pins

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high (port reset), sampled only at posedge clk.
- Register map (addr):
  - 0 DATA: R/W.
  - 1 SET: W1S on DATA; reads 0.
  - 2 CLR: W1C on DATA; reads 0.
  - 3 TGL: W1T on DATA; reads 0.
  - 4 BLINK_EN: R/W, per-bit blink enable.
  - 5 BLINK_DIV: R/W, CNT_W bits.
  - 6 STATUS: R; bit0 = phase, bits[CNT_W:1] = cnt.
  - 7: unmapped; reads 0, writes ignored.
- Width rules:
  - Only wdata[GPO_W-1:0] is used (wdata[CNT_W-1:0] for BLINK_DIV); upper bits are ignored.
  - rdata is zero-extended.
  - With CNT_W > 31, STATUS cnt is truncated to the low 31 bits.
- Reset: DATA=0, BLINK_EN=0, BLINK_DIV=0, cnt=0, phase=1. gpo = all 0 (all 1 if ACTIVE_LOW). rdata follows addr, with register values all 0 except STATUS = 1.
- Write latency: the new value is in the register after the posedge where cs&wr; gpo reflects it in that same cycle (gpo is combinational from registers). Reads have zero latency, with no side effects.
- Only one register is written per cycle. SET/CLR/TGL modify only the DATA bits that are 1 in wdata; other DATA bits hold.
- Output function, per bit i:
  - out_i = DATA[i] & (~BLINK_EN[i] | phase).
  - gpo[i] = out_i ^ ACTIVE_LOW.
- Prescaler state machine (two state bits: cnt, phase):
  - BLINK_DIV == 0: idle. cnt held 0, phase held 1, so blink bits appear steadily on.
  - BLINK_DIV == N > 0: each cycle, cnt increments. When cnt == N, cnt <= 0 and phase toggles. The half-period is N+1 cycles; the full blink period is 2(N+1) cycles.
  - The prescaler runs regardless of BLINK_EN.
- Boundary conditions:
  - Write to BLINK_DIV (any value, including the same value): cnt <= 0, phase <= 1 at that edge. This takes priority over a coincident terminal count.
  - Decreasing BLINK_DIV below the current cnt cannot cause a runaway count, because the write itself restarts cnt at 0.
  - cnt never exceeds BLINK_DIV.
  - Toggling BLINK_EN does not disturb cnt or phase.
  - Writing DATA or TGL during blink changes the output immediately, with the current phase applied.
  - reset asserted mid-blink: all state returns to reset values at that edge, and reset dominates a coincident write.
  - cs=0 or wr=0: no state change except prescaler advance.

Test Plan:
- Reset, then write DATA=0x0000_01A5 (GPO_W=8) -> gpo=0xA5, read addr0=0x0000_00A5; assert reset -> gpo=0x00, DATA reads 0.
- DATA=0x0F; SET 0x30 -> 0x3F; CLR 0x03 -> 0x3C; TGL 0xFF -> 0xC3; reads of addr1..3 return 0 throughout.
- DATA=0xFF, BLINK_EN=0x01, BLINK_DIV=3 -> gpo[0] high 4 cycles, low 4 cycles, repeating. gpo[7:1] stays 0x7F-pattern high. STATUS cnt sequence 0,1,2,3,0.
- During blink with phase=0 at cnt=2, write BLINK_DIV=1 -> next cycle cnt=0, phase=1, gpo[0]=1; half-period is then 2 cycles.
- BLINK_DIV=0 with BLINK_EN=0xFF, DATA=0x55 -> gpo steady 0x55 for 100 cycles, STATUS=0x1.
- ACTIVE_LOW=1 build: after reset gpo=0xFF; DATA=0x81 -> gpo=0x7E, DATA reads 0x81. Write to addr7 -> no change, read addr7=0.

Source files
------------

// File: rtl/gpo_blink.sv
// Memory-mapped general-purpose output port with atomic set/clear/toggle
// registers and per-bit hardware blink driven by a shared prescaler.
module gpo_blink #(
  parameter int GPO_W      = 8,
  parameter int CNT_W      = 24,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             wr,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [GPO_W-1:0] gpo
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_SET    = 3'd1;
  localparam logic [2:0] A_CLR    = 3'd2;
  localparam logic [2:0] A_TGL    = 3'd3;
  localparam logic [2:0] A_EN     = 3'd4;
  localparam logic [2:0] A_DIV    = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

  // STATUS has one bit for phase, leaving 31 bits for the counter.
  localparam int STAT_W = (CNT_W > 31) ? 31 : CNT_W;

  logic [GPO_W-1:0] data_reg, data_next;
  logic [GPO_W-1:0] blink_en_reg, blink_en_next;
  logic [CNT_W-1:0] blink_div_reg, blink_div_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             phase_reg, phase_next;

  logic             we;
  logic             div_write;
  logic [GPO_W-1:0] wbits;
  logic [CNT_W-1:0] wdiv;
  logic [31:0]      status;
  logic             unused_bits;

  assign we        = cs & wr;
  assign div_write = we && (addr == A_DIV);
  assign wbits     = GPO_W'(wdata);
  assign wdiv      = CNT_W'(wdata);

  always_comb begin
    data_next      = data_reg;
    blink_en_next  = blink_en_reg;
    blink_div_next = blink_div_reg;
    if (we) begin
      case (addr)
        A_DATA:  data_next      = wbits;
        A_SET:   data_next      = data_reg | wbits;
        A_CLR:   data_next      = data_reg & ~wbits;
        A_TGL:   data_next      = data_reg ^ wbits;
        A_EN:    blink_en_next  = wbits;
        A_DIV:   blink_div_next = wdiv;
        default: ;
      endcase
    end
  end

  // A divider write restarts the half-period, so shrinking the divider below
  // the running count can never let the counter overshoot.
  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (div_write || (blink_div_reg == '0)) begin
      cnt_next   = '0;
      phase_next = 1'b1;
    end else if (cnt_reg == blink_div_reg) begin
      cnt_next   = '0;
      phase_next = ~phase_reg;
    end else begin
      cnt_next   = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg      <= '0;
      blink_en_reg  <= '0;
      blink_div_reg <= '0;
      cnt_reg       <= '0;
      phase_reg     <= 1'b1;
    end else begin
      data_reg      <= data_next;
      blink_en_reg  <= blink_en_next;
      blink_div_reg <= blink_div_next;
      cnt_reg       <= cnt_next;
      phase_reg     <= phase_next;
    end
  end

  assign status = 32'({cnt_reg[STAT_W-1:0], phase_reg});

  always_comb begin
    rdata = '0;
    case (addr)
      A_DATA:   rdata = 32'(data_reg);
      A_EN:     rdata = 32'(blink_en_reg);
      A_DIV:    rdata = 32'(blink_div_reg);
      A_STATUS: rdata = status;
      default:  rdata = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < GPO_W; gi++) begin : g_out
      assign gpo[gi] = (data_reg[gi] & (~blink_en_reg[gi] | phase_reg)) ^ ACTIVE_LOW;
    end
  endgenerate

  // Upper write-data bits and truncated counter bits are deliberately dropped.
  assign unused_bits = ^{wdata, cnt_reg};

endmodule

// File: tb/tb_gpo_blink.sv
// Bench for gpo_blink: directed scenarios then random bus traffic, checked
// against an arithmetic model of the register map and blink timing.
`timescale 1ns/1ps
module tb_gpo_blink;

  logic        clk = 1'b0;
  logic        reset, cs, wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata_al;
  logic [7:0]  gpo, gpo_al;

  int checks = 0;
  int errors = 0;

  // Model: register contents plus cycles elapsed since the prescaler restart.
  logic [7:0]  m_data, m_en;
  int unsigned m_div;
  longint      m_t;

  always #10 clk = ~clk;

  gpo_blink #(.GPO_W(8), .CNT_W(24), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .gpo(gpo)
  );

  gpo_blink #(.GPO_W(8), .CNT_W(24), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata_al), .gpo(gpo_al)
  );

  function automatic int unsigned m_cnt();
    return (m_div == 0) ? 0 : int'(m_t % longint'(m_div + 1));
  endfunction

  function automatic logic m_phase();
    return (m_div == 0) ? 1'b1 : (((m_t / longint'(m_div + 1)) % 2) == 0);
  endfunction

  function automatic logic [7:0] m_gpo();
    return m_data & (~m_en | {8{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, m_data};
      3'd4:    return {24'd0, m_en};
      3'd5:    return m_div;
      3'd6:    return (m_cnt() << 1) | {31'd0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic r, c, w, input logic [2:0] a, input logic [31:0] d);
    if (r) begin
      m_data = 8'h00; m_en = 8'h00; m_div = 0; m_t = 0;
    end else begin
      if (c && w && a == 3'd5) begin
        m_div = d[23:0];
        m_t   = 0;
      end else if (m_div != 0) begin
        m_t++;
      end
      if (c && w) begin
        case (a)
          3'd0: m_data = d[7:0];
          3'd1: m_data = m_data | d[7:0];
          3'd2: m_data = m_data & ~d[7:0];
          3'd3: m_data = m_data ^ d[7:0];
          3'd4: m_en   = d[7:0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after an edge: outputs of both builds plus every register read.
  task automatic verify();
    logic [7:0] g;
    g = m_gpo();
    check("gpo", {24'd0, gpo}, {24'd0, g});
    check("gpo_al", {24'd0, gpo_al}, {24'd0, ~g});
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      check($sformatf("rd%0d", a), rdata, m_read(3'(a)));
      check($sformatf("rd%0d_al", a), rdata_al, m_read(3'(a)));
    end
  endtask

  task automatic cycle(input logic r, c, w, input logic [2:0] a, input logic [31:0] d);
    reset = r; cs = c; wr = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(r, c, w, a, d);
    #1;
    reset = 1'b0; cs = 1'b0; wr = 1'b0; wdata = $urandom;
    verify();
    $display("cyc rst=%0b cs=%0b wr=%0b addr=%0d wdata=%h gpo=%h status=%h",
             r, c, w, a, d, gpo, m_read(3'd6));
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'(i), 32'hFFFF_FFFF);
  endtask

  initial begin
    logic found;
    logic r, c, w;
    logic [2:0] a;
    logic [31:0] d;
    reset = 1'b1; cs = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'd0;
    m_data = 8'h00; m_en = 8'h00; m_div = 0; m_t = 0;

    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);

    wr_reg(3'd0, 32'h0000_01A5);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);

    wr_reg(3'd0, 32'h0F);
    wr_reg(3'd1, 32'h30);
    wr_reg(3'd2, 32'h03);
    wr_reg(3'd3, 32'hFF);

    wr_reg(3'd0, 32'hFF);
    wr_reg(3'd4, 32'h01);
    wr_reg(3'd5, 32'd3);
    idle(20);

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt() == 2 && m_phase() == 1'b0) found = 1'b1;
      else idle(1);
    end
    check("wait_phase0", {31'd0, found}, 32'd1);
    wr_reg(3'd5, 32'd1);
    idle(10);

    wr_reg(3'd5, 32'd0);
    wr_reg(3'd4, 32'hFF);
    wr_reg(3'd0, 32'h55);
    idle(100);

    wr_reg(3'd7, 32'hFFFF_FFFF);
    wr_reg(3'd5, 32'd2);
    idle(5);
    wr_reg(3'd4, 32'h00);
    wr_reg(3'd4, 32'hF0);
    wr_reg(3'd3, 32'h0F);
    idle(4);
    cycle(1'b1, 1'b1, 1'b1, 3'd0, 32'hFF);

    for (int i = 0; i < 500; i++) begin
      r = ($urandom_range(0, 63) == 0);
      c = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd5 && $urandom_range(0, 9) != 0) d = $urandom_range(0, 6);
      cycle(r, c, w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
